// File: rtl/input_port_unit_pkg.sv
// -----------------------------------------------------------------------------
// input_port_unit_pkg
// Shared NoC definitions used by the router input ports and the switch
// allocator: destination port codes, flit type codes, head-flit field
// positions and the XY route helper.
// -----------------------------------------------------------------------------
package input_port_unit_pkg;

    // Destination codes presented to the switch allocator
    localparam logic [2:0] EMPTY          = 3'd0;
    localparam logic [2:0] OUT_X1_PORT    = 3'd1;
    localparam logic [2:0] OUT_X2_PORT    = 3'd2;
    localparam logic [2:0] OUT_Y1_PORT    = 3'd3;
    localparam logic [2:0] OUT_LOCAL_PORT = 3'd4;

    // Flit type carried in the two most significant bits
    typedef enum logic [1:0] {
        FT_BODY   = 2'b00,
        FT_HEAD   = 2'b01,
        FT_TAIL   = 2'b10,
        FT_SINGLE = 2'b11
    } flit_type_e;

    // Input port route-holding state
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } ipu_state_e;

    // Field positions as offsets below FLIT_W (bit index = FLIT_W - offset)
    localparam int TYPE_HI_OFS  = 1;
    localparam int TYPE_LO_OFS  = 2;
    localparam int DST_X_HI_OFS = 3;
    localparam int DST_X_LO_OFS = 4;
    localparam int DST_Y_OFS    = 5;

    function automatic logic is_head_type(input flit_type_e t);
        return (t == FT_HEAD) || (t == FT_SINGLE);
    endfunction

    function automatic logic is_tail_type(input flit_type_e t);
        return (t == FT_TAIL) || (t == FT_SINGLE);
    endfunction

    // Dimension-ordered routing: resolve X first, then Y, else deliver locally
    function automatic logic [2:0] xy_route(input logic [1:0] dst_x,
                                            input logic       dst_y,
                                            input logic [1:0] my_x,
                                            input logic       my_y);
        logic [2:0] r;
        if (dst_x > my_x) begin
            r = OUT_X2_PORT;
        end else if (dst_x < my_x) begin
            r = OUT_X1_PORT;
        end else if (dst_y != my_y) begin
            r = OUT_Y1_PORT;
        end else begin
            r = OUT_LOCAL_PORT;
        end
        return r;
    endfunction

endpackage

// File: rtl/noc_flit_fifo.sv
// -----------------------------------------------------------------------------
// noc_flit_fifo
// Small circular flit buffer with read/write pointers wrapping modulo DEPTH.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   wr_data     flit to store when push is high
//   push        store wr_data (caller guarantees !full)
//   pop         retire the front entry (caller guarantees !empty)
//   front       current front entry, combinational from storage
//   full/empty  occupancy flags
// -----------------------------------------------------------------------------
module noc_flit_fifo #(
    parameter int FLIT_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [FLIT_W-1:0] wr_data,
    input  logic              push,
    input  logic              pop,
    output logic [FLIT_W-1:0] front,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [FLIT_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [PTR_W:0]    count_r;

    // Storage, pointers and occupancy count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push) begin
                mem_r[wr_ptr_r] <= wr_data;
                wr_ptr_r        <= wr_ptr_r + 1'b1;
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    assign front = mem_r[rd_ptr_r];
    assign full  = (count_r == FULL_CNT);
    assign empty = (count_r == '0);

endmodule

// File: rtl/input_port_unit.sv
// -----------------------------------------------------------------------------
// input_port_unit
// Router input port: buffers incoming flits, computes the XY route of each
// head flit and holds it (wormhole) until the tail flit departs.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   in_flit      flit from upstream link, qualified by in_valid
//   in_busy      FIFO full; upstream holds its flit
//   port_dst     held destination code for the switch allocator
//   port_dst_en  one-cycle pulse whenever port_dst changes
//   grant        crossbar consumes the front flit this cycle
//   out_flit     FIFO front flit
//   out_valid    front flit is valid and its route is held
//   err_drop     one-cycle pulse when an orphan body/tail flit is discarded
// -----------------------------------------------------------------------------
module input_port_unit
    import input_port_unit_pkg::*;
#(
    parameter int FLIT_W  = 32,
    parameter int DEPTH   = 4,
    parameter int X_COORD = 0,
    parameter int Y_COORD = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [FLIT_W-1:0] in_flit,
    input  logic              in_valid,
    output logic              in_busy,
    output logic [2:0]        port_dst,
    output logic              port_dst_en,
    input  logic              grant,
    output logic [FLIT_W-1:0] out_flit,
    output logic              out_valid,
    output logic              err_drop
);

    localparam logic [1:0] MY_X = 2'(X_COORD);
    localparam logic       MY_Y = 1'(Y_COORD);

    logic              full_s;
    logic              empty_s;
    logic              push_s;
    logic              pop_s;
    logic [FLIT_W-1:0] front_s;
    flit_type_e        front_type_s;
    logic [2:0]        route_s;

    ipu_state_e        state_r;
    logic [2:0]        port_dst_r;
    logic              port_dst_en_r;
    logic              err_drop_r;

    // A flit offered while full is not stored, even if a pop frees a slot
    assign push_s = in_valid && !full_s;

    noc_flit_fifo #(
        .FLIT_W (FLIT_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_data (in_flit),
        .push    (push_s),
        .pop     (pop_s),
        .front   (front_s),
        .full    (full_s),
        .empty   (empty_s)
    );

    // Decode the front flit's type and its XY route
    always_comb begin
        front_type_s = flit_type_e'(front_s[FLIT_W-TYPE_HI_OFS:FLIT_W-TYPE_LO_OFS]);
        route_s      = xy_route(front_s[FLIT_W-DST_X_HI_OFS:FLIT_W-DST_X_LO_OFS],
                                front_s[FLIT_W-DST_Y_OFS], MY_X, MY_Y);
    end

    // Pop on grant while a route is held; in IDLE, discard orphan body/tail flits
    always_comb begin
        pop_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!empty_s && !is_head_type(front_type_s)) begin
                    pop_s = 1'b1;
                end else begin
                    pop_s = 1'b0;
                end
            end
            ST_ACTIVE: begin
                if (grant && !empty_s) begin
                    pop_s = 1'b1;
                end else begin
                    pop_s = 1'b0;
                end
            end
            default: pop_s = 1'b0;
        endcase
    end

    // Route-holding FSM with registered destination and pulse outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            port_dst_r    <= EMPTY;
            port_dst_en_r <= 1'b0;
            err_drop_r    <= 1'b0;
        end else begin
            port_dst_en_r <= 1'b0;
            err_drop_r    <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (!empty_s) begin
                        if (is_head_type(front_type_s)) begin
                            port_dst_r    <= route_s;
                            port_dst_en_r <= 1'b1;
                            state_r       <= ST_ACTIVE;
                        end else begin
                            err_drop_r <= 1'b1;
                        end
                    end
                end
                ST_ACTIVE: begin
                    // Releasing through IDLE guarantees one EMPTY cycle between packets
                    if (pop_s && is_tail_type(front_type_s)) begin
                        port_dst_r    <= EMPTY;
                        port_dst_en_r <= 1'b1;
                        state_r       <= ST_IDLE;
                    end
                end
                default: begin
                    port_dst_r <= EMPTY;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_busy     = full_s;
    assign out_flit    = front_s;
    assign out_valid   = (state_r == ST_ACTIVE) && !empty_s;
    assign port_dst    = port_dst_r;
    assign port_dst_en = port_dst_en_r;
    assign err_drop    = err_drop_r;

endmodule

// File: tb/tb_input_port_unit.sv
// -----------------------------------------------------------------------------
// tb_input_port_unit
// Directed bench for input_port_unit at X_COORD=1, Y_COORD=0, DEPTH=4.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_input_port_unit;

    localparam int FW = 32;

    logic          clk;
    logic          rst_n;
    logic [FW-1:0] in_flit;
    logic          in_valid;
    logic          in_busy;
    logic [2:0]    port_dst;
    logic          port_dst_en;
    logic          grant;
    logic [FW-1:0] out_flit;
    logic          out_valid;
    logic          err_drop;

    int checks_cnt;
    int errors_cnt;

    logic [FW-1:0] pkt [6];

    input_port_unit #(
        .FLIT_W  (FW),
        .DEPTH   (4),
        .X_COORD (1),
        .Y_COORD (0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_flit     (in_flit),
        .in_valid    (in_valid),
        .in_busy     (in_busy),
        .port_dst    (port_dst),
        .port_dst_en (port_dst_en),
        .grant       (grant),
        .out_flit    (out_flit),
        .out_valid   (out_valid),
        .err_drop    (err_drop)
    );

    // Free-running clock, period 10
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [FW-1:0] mk(input logic [1:0] t, input logic [1:0] dx,
                                         input logic dy, input logic [26:0] pl);
        return {t, dx, dy, pl};
    endfunction

    // Single-flit packet: route appears two edges after the push, clears after the pop
    task automatic send_single(input string tag, input logic [1:0] dx, input logic dy,
                               input logic [2:0] exp_dst);
        logic [FW-1:0] f;
        f = mk(2'b11, dx, dy, 27'h155);
        in_flit  = f;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check_eq({tag, "_dst_pre"}, {29'd0, port_dst}, 32'd0);
        step();
        check_eq({tag, "_dst"}, {29'd0, port_dst}, {29'd0, exp_dst});
        check_eq({tag, "_en"}, {31'd0, port_dst_en}, 32'd1);
        check_eq({tag, "_flit"}, out_flit, f);
        step();
        check_eq({tag, "_en_off"}, {31'd0, port_dst_en}, 32'd0);
        check_eq({tag, "_hold"}, {29'd0, port_dst}, {29'd0, exp_dst});
        grant = 1'b1;
        step();
        grant = 1'b0;
        check_eq({tag, "_rel_dst"}, {29'd0, port_dst}, 32'd0);
        check_eq({tag, "_rel_en"}, {31'd0, port_dst_en}, 32'd1);
        check_eq({tag, "_rel_vld"}, {31'd0, out_valid}, 32'd0);
        step();
    endtask

    initial begin
        checks_cnt = 0;
        errors_cnt = 0;
        rst_n      = 1'b0;
        in_flit    = '0;
        in_valid   = 1'b0;
        grant      = 1'b0;
        #1;
        check_eq("rst_busy", {31'd0, in_busy}, 32'd0);
        check_eq("rst_dst", {29'd0, port_dst}, 32'd0);
        check_eq("rst_en", {31'd0, port_dst_en}, 32'd0);
        check_eq("rst_vld", {31'd0, out_valid}, 32'd0);
        check_eq("rst_drop", {31'd0, err_drop}, 32'd0);
        check_eq("rst_flit", out_flit, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Routing table at (1,0)
        send_single("r30", 2'd3, 1'b0, 3'd2);
        send_single("r01", 2'd0, 1'b1, 3'd1);
        send_single("r11", 2'd1, 1'b1, 3'd3);
        send_single("r10", 2'd1, 1'b0, 3'd4);
        send_single("r00", 2'd0, 1'b0, 3'd1);
        send_single("r21", 2'd2, 1'b1, 3'd2);

        // HEAD + 4 BODY + TAIL with grant low: fills after 4 flits
        pkt[0] = mk(2'b01, 2'd3, 1'b1, 27'h0000A0);
        pkt[1] = mk(2'b00, 2'd0, 1'b0, 27'h0000B1);
        pkt[2] = mk(2'b00, 2'd0, 1'b0, 27'h0000B2);
        pkt[3] = mk(2'b00, 2'd0, 1'b0, 27'h0000B3);
        pkt[4] = mk(2'b00, 2'd0, 1'b0, 27'h0000B4);
        pkt[5] = mk(2'b10, 2'd0, 1'b0, 27'h0000C5);
        for (int i = 0; i < 4; i++) begin
            check_eq("fill_busy_lo", {31'd0, in_busy}, 32'd0);
            in_flit  = pkt[i];
            in_valid = 1'b1;
            step();
        end
        check_eq("full_busy", {31'd0, in_busy}, 32'd1);
        check_eq("wh_dst", {29'd0, port_dst}, 32'd2);
        in_flit = pkt[4];
        step();
        check_eq("held_busy", {31'd0, in_busy}, 32'd1);
        check_eq("held_front", out_flit, pkt[0]);
        check_eq("held_vld", {31'd0, out_valid}, 32'd1);
        // Full with grant and in_valid: pop only, count 4 -> 3
        grant = 1'b1;
        step();
        check_eq("popfull_busy", {31'd0, in_busy}, 32'd0);
        check_eq("popfull_front", out_flit, pkt[1]);
        // Push and pop together: count stays 3
        step();
        check_eq("pp_busy", {31'd0, in_busy}, 32'd0);
        check_eq("pp_front", out_flit, pkt[2]);
        in_flit = pkt[5];
        step();
        check_eq("pp2_front", out_flit, pkt[3]);
        in_valid = 1'b0;
        step();
        check_eq("b4_front", out_flit, pkt[4]);
        check_eq("b4_dst", {29'd0, port_dst}, 32'd2);
        check_eq("b4_en", {31'd0, port_dst_en}, 32'd0);
        step();
        check_eq("tail_front", out_flit, pkt[5]);
        check_eq("tail_dst", {29'd0, port_dst}, 32'd2);
        check_eq("tail_vld", {31'd0, out_valid}, 32'd1);
        step();
        grant = 1'b0;
        check_eq("wh_rel_dst", {29'd0, port_dst}, 32'd0);
        check_eq("wh_rel_en", {31'd0, port_dst_en}, 32'd1);
        check_eq("wh_rel_vld", {31'd0, out_valid}, 32'd0);
        step();

        // Orphan BODY in IDLE is dropped
        in_flit  = mk(2'b00, 2'd2, 1'b0, 27'h0000D0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check_eq("orph_vld", {31'd0, out_valid}, 32'd0);
        check_eq("orph_drop0", {31'd0, err_drop}, 32'd0);
        step();
        check_eq("orph_drop", {31'd0, err_drop}, 32'd1);
        check_eq("orph_dst", {29'd0, port_dst}, 32'd0);
        check_eq("orph_en", {31'd0, port_dst_en}, 32'd0);
        step();
        check_eq("orph_drop_off", {31'd0, err_drop}, 32'd0);
        send_single("after_orph", 2'd0, 1'b0, 3'd1);

        // Back-to-back singles with grant held: one IDLE cycle between routes
        grant    = 1'b1;
        in_flit  = mk(2'b11, 2'd3, 1'b0, 27'h0000E1);
        in_valid = 1'b1;
        step();
        in_flit  = mk(2'b11, 2'd1, 1'b1, 27'h0000E2);
        step();
        in_valid = 1'b0;
        check_eq("b2b_dst1", {29'd0, port_dst}, 32'd2);
        step();
        check_eq("b2b_gap_dst", {29'd0, port_dst}, 32'd0);
        check_eq("b2b_gap_vld", {31'd0, out_valid}, 32'd0);
        step();
        check_eq("b2b_dst2", {29'd0, port_dst}, 32'd3);
        check_eq("b2b_en2", {31'd0, port_dst_en}, 32'd1);
        step();
        grant = 1'b0;
        check_eq("b2b_rel", {29'd0, port_dst}, 32'd0);
        step();

        // Reset mid-packet with a full FIFO
        for (int i = 0; i < 4; i++) begin
            in_flit  = pkt[i];
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        check_eq("mid_busy", {31'd0, in_busy}, 32'd1);
        check_eq("mid_dst", {29'd0, port_dst}, 32'd2);
        rst_n = 1'b0;
        #1;
        check_eq("mrst_busy", {31'd0, in_busy}, 32'd0);
        check_eq("mrst_dst", {29'd0, port_dst}, 32'd0);
        check_eq("mrst_vld", {31'd0, out_valid}, 32'd0);
        check_eq("mrst_flit", out_flit, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        send_single("post_rst", 2'd0, 1'b1, 3'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
